// File: rtl/serial_comparator_pkg.sv
// Shared verdict encoding and single-bit comparison helper for the serial comparators.
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_state_t;

    function automatic cmp_state_t cmp_bit(input logic i_a, input logic i_b);
        cmp_state_t w_res;
        unique case ({i_a, i_b})
            2'b01:   w_res = CMP_LT;
            2'b10:   w_res = CMP_GT;
            default: w_res = CMP_EQ;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/serial_comparator_least_significant_first.sv
// Bit-serial unsigned comparator, least significant bit first: the newest differing bit
// dominates, so any a != b overrides the accumulated verdict.
module serial_comparator_least_significant_first
    import serial_comparator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    cmp_state_t r_state;
    cmp_state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CMP_EQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (a != b) begin
            w_next = cmp_bit(a, b);
        end
    end

    // Outputs show the verdict including the bit currently on a/b.
    always_comb begin
        a_less_b    = (w_next == CMP_LT);
        a_eq_b      = (w_next == CMP_EQ);
        a_greater_b = (w_next == CMP_GT);
    end

endmodule

// File: rtl/serial_comparator_most_significant_first.sv
// Bit-serial unsigned comparator, most significant bit first: the first differing bit
// decides the verdict for the rest of the word.
module serial_comparator_most_significant_first
    import serial_comparator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic a_less_b,
    output logic a_eq_b,
    output logic a_greater_b
);

    cmp_state_t r_state;
    cmp_state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CMP_EQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == CMP_EQ) begin
            w_next = cmp_bit(a, b);
        end
    end

    always_comb begin
        a_less_b    = (w_next == CMP_LT);
        a_eq_b      = (w_next == CMP_EQ);
        a_greater_b = (w_next == CMP_GT);
    end

endmodule

// File: rtl/serial_comparator_pair.sv
// Runs LSB-first and MSB-first serial comparisons side by side on the same bit streams.
module serial_comparator_pair (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic lsf_less,
    output logic lsf_eq,
    output logic lsf_greater,
    output logic msf_less,
    output logic msf_eq,
    output logic msf_greater
);

    serial_comparator_least_significant_first u_lsf (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .a_less_b    (lsf_less),
        .a_eq_b      (lsf_eq),
        .a_greater_b (lsf_greater)
    );

    serial_comparator_most_significant_first u_msf (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .a_less_b    (msf_less),
        .a_eq_b      (msf_eq),
        .a_greater_b (msf_greater)
    );

endmodule

// File: tb/tb_serial_comparator_pair.sv
// Scoreboard bench for serial_comparator_pair: an integer-arithmetic reference model feeds
// an expectation queue that a monitor checks before and after every consuming edge.
module tb_serial_comparator_pair;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic lsf_less, lsf_eq, lsf_greater;
    logic msf_less, msf_eq, msf_greater;

    serial_comparator_pair dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .lsf_less    (lsf_less),
        .lsf_eq      (lsf_eq),
        .lsf_greater (lsf_greater),
        .msf_less    (msf_less),
        .msf_eq      (msf_eq),
        .msf_greater (msf_greater)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] idx;
        logic [2:0]  lsf;
        logic [2:0]  msf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the words streamed since the last reset, held as plain integers.
    logic [63:0] m_lsf_a, m_lsf_b, m_msf_a, m_msf_b;
    int          m_n;

    logic [15:0] m_ll, m_le, m_lg, m_ml, m_me, m_mg;
    logic [2:0]  last_lsf, last_msf;

    // {less, eq, greater}
    function automatic logic [2:0] cmp3(input logic [63:0] x, input logic [63:0] y);
        if (x < y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63 - i];
        return r;
    endfunction

    task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        logic [2:0] gl, gm;
        gl = {lsf_less, lsf_eq, lsf_greater};
        gm = {msf_less, msf_eq, msf_greater};
        total++;
        if (!$onehot(gl) || !$onehot(gm)) begin
            bad++;
            $display("FAIL %s onehot bit %0d: lsf %b msf %b want one-hot", tag, e.idx, gl, gm);
        end
        check3({tag, " lsf"}, gl, e.lsf);
        check3({tag, " msf"}, gm, e.msf);
    endtask

    // Before the edge: verdict must already include the presented bit.
    initial forever begin
        @(negedge clk);
        #1;
        if (q.size() > 0) check_entry("pre-edge", q[0]);
    end

    // After the edge: verdict must be unchanged while a/b hold.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_entry("post-edge", e);
            last_lsf = {lsf_less, lsf_eq, lsf_greater};
            last_msf = {msf_less, msf_eq, msf_greater};
            if (e.idx < 16) begin
                m_ll[e.idx[3:0]] = lsf_less;
                m_le[e.idx[3:0]] = lsf_eq;
                m_lg[e.idx[3:0]] = lsf_greater;
                m_ml[e.idx[3:0]] = msf_less;
                m_me[e.idx[3:0]] = msf_eq;
                m_mg[e.idx[3:0]] = msf_greater;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'($urandom);
        b   = 1'($urandom);
        m_lsf_a = '0; m_lsf_b = '0; m_msf_a = '0; m_msf_b = '0; m_n = 0;
        {m_ll, m_le, m_lg, m_ml, m_me, m_mg} = '0;
    endtask

    task automatic send_bit(input logic ba, input logic bb);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        a   = ba;
        b   = bb;
        m_lsf_a = m_lsf_a | (64'(ba) << m_n);
        m_lsf_b = m_lsf_b | (64'(bb) << m_n);
        m_msf_a = {m_msf_a[62:0], ba};
        m_msf_b = {m_msf_b[62:0], bb};
        e.idx = 32'(m_n);
        e.lsf = cmp3(m_lsf_a, m_lsf_b);
        e.msf = cmp3(m_msf_a, m_msf_b);
        q.push_back(e);
        m_n++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left want 0", q.size());
        end
    endtask

    task automatic run_word(input string name, input logic [15:0] wa, input logic [15:0] wb,
                            input logic [15:0] ll, input logic [15:0] le, input logic [15:0] lg,
                            input logic [15:0] ml, input logic [15:0] me, input logic [15:0] mg);
        do_reset();
        for (int i = 0; i < 16; i++) send_bit(wa[i], wb[i]);
        drain();
        check16({name, " lsf_less"}, m_ll, ll);
        check16({name, " lsf_eq"}, m_le, le);
        check16({name, " lsf_greater"}, m_lg, lg);
        check16({name, " msf_less"}, m_ml, ml);
        check16({name, " msf_eq"}, m_me, me);
        check16({name, " msf_greater"}, m_mg, mg);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] wa, wb;
        repeat (2) @(posedge clk);

        run_word("w1", 16'h4126, 16'h4646,
                 16'hFEC0, 16'h001F, 16'h0120, 16'h0000, 16'h001F, 16'hFFE0);
        run_word("w2", 16'h4106, 16'h5646,
                 16'hFEC0, 16'h003F, 16'h0100, 16'hFFC0, 16'h003F, 16'h0000);
        run_word("w3", 16'h4726, 16'h4726,
                 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);

        // Reset in the middle of a word: history must be discarded.
        do_reset();
        send_bit(1'b1, 1'b0);
        do_reset();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        drain();
        check3("midreset lsf final", last_lsf, 3'b100);
        check3("midreset msf final", last_msf, 3'b100);

        for (int t = 0; t < 8; t++) begin
            wa = {$urandom(), $urandom()};
            wb = {$urandom(), $urandom()};
            if (t == 0) wb = wa;
            if (t == 1) wb = wa ^ 64'h1;
            do_reset();
            for (int i = 0; i < 64; i++) send_bit(wa[i], wb[i]);
            drain();
            check3("random lsf final", last_lsf, cmp3(wa, wb));
            check3("random msf final", last_msf, cmp3(rev64(wa), rev64(wb)));
        end

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
